// File: rtl/dispenser_pkg.sv
// Shared types and widths for the pet food dispenser sequencer.
//   state_t   : sequencer states (IDLE, WAIT, GAP_D, DISPENSE, GAP_W)
//   TMR_LIM_W : width of the limit presented to the Temporizador timer
//   TMR_CNT_W : width of the timer count (numero)
//   PORT_W    : width of the portion counter
package dispenser_pkg;

  localparam int TMR_LIM_W = 8;
  localparam int TMR_CNT_W = 16;
  localparam int PORT_W    = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT     = 3'd1,
    GAP_D    = 3'd2,
    DISPENSE = 3'd3,
    GAP_W    = 3'd4
  } state_t;

endpackage

// File: rtl/dispense_scheduler_req_sync_edge.sv
// Pushbutton conditioning for the manual dispense request.
// SYNC_STAGES-deep synchronizer followed by a rising-edge detector.
//   clk   in  : system clock
//   reset in  : asynchronous active-low reset
//   din   in  : raw asynchronous input
//   rise  out : one-cycle pulse on a synchronized 0->1 transition
module req_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/dispense_scheduler.sv
// Top-level sequencer for the pet food dispenser.
// Alternates an inter-meal wait with a gate-open dispense phase using an
// external up-counting timer, arbitrates a manual pushbutton against the
// schedule, skips dispensing on a full bowl and keeps a saturating,
// capped portion count.
//
// Optional feature: define DISPENSE_MANUAL_EN to enable the manual request
// path (synchronizer, edge detect, pending flag). Without it manual_req is
// ignored and only scheduled dispenses occur.
//
// Ports:
//   clk, reset (async active-low)
//   enable        in  : scheduled operation on/off
//   interval_lim  in  : wait length, latched on entry to WAIT
//   dispense_lim  in  : gate-open length, latched on entry to DISPENSE
//   manual_req    in  : raw pushbutton (asynchronous)
//   bowl_full     in  : skip the current dispense when high
//   count_clr     in  : synchronous clear of portions
//   tmr_numero    in  : timer count
//   tmr_init      out : timer run (0 clears the timer)
//   tmr_limite    out : limit presented to the timer
//   gate_open     out : gate drive
//   portions      out : dispenses since last clear, saturating
//   busy          out : state != IDLE
//   cap_reached   out : portions >= MAX_PORTIONS (one cycle behind portions)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | timer cleared, waiting for enable or a manual request
// WAIT     | timer running the inter-meal interval
// GAP_D    | one-cycle timer clear; decide dispense vs skip, load gate time
// DISPENSE | gate open, timer running the gate-open time
// GAP_W    | one-cycle timer clear; load interval, back to WAIT or IDLE
module dispense_scheduler
  import dispenser_pkg::*;
#(
  parameter logic [PORT_W-1:0] MAX_PORTIONS = 8'd6,
  parameter int                SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [TMR_LIM_W-1:0] interval_lim,
  input  logic [TMR_LIM_W-1:0] dispense_lim,
  input  logic                 manual_req,
  input  logic                 bowl_full,
  input  logic                 count_clr,
  input  logic [TMR_CNT_W-1:0] tmr_numero,
  output logic                 tmr_init,
  output logic [TMR_LIM_W-1:0] tmr_limite,
  output logic                 gate_open,
  output logic [PORT_W-1:0]    portions,
  output logic                 busy,
  output logic                 cap_reached
);

  state_t               state_q, state_d;
  logic [TMR_LIM_W-1:0] lim_d;
  logic                 phase_done;
  logic                 pend_q;
  logic                 dispense_entry;

  assign phase_done = tmr_numero >= {{(TMR_CNT_W-TMR_LIM_W){1'b0}}, tmr_limite};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pend_q) state_d = GAP_D;
                else if (enable) state_d = WAIT;
      WAIT:     if (phase_done || pend_q) state_d = GAP_D;
                else if (!enable) state_d = IDLE;
      GAP_D:    state_d = (bowl_full || cap_reached) ? GAP_W : DISPENSE;
      DISPENSE: if (phase_done) state_d = GAP_W;
      GAP_W:    state_d = enable ? WAIT : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // The limit must be valid in the first cycle of a running phase, so it is
  // loaded on the edge that enters that phase.
  always_comb begin
    lim_d = tmr_limite;
    case (state_q)
      IDLE:    if (state_d == WAIT) lim_d = interval_lim;
      GAP_D:   lim_d = dispense_lim;
      GAP_W:   lim_d = interval_lim;
      default: lim_d = tmr_limite;
    endcase
  end

  // Outputs are flopped from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tmr_init   <= 1'b0;
      gate_open  <= 1'b0;
      busy       <= 1'b0;
      tmr_limite <= '0;
    end else begin
      state_q    <= state_d;
      tmr_init   <= (state_d == WAIT) || (state_d == DISPENSE);
      gate_open  <= (state_d == DISPENSE);
      busy       <= (state_d != IDLE);
      tmr_limite <= lim_d;
    end
  end

  assign dispense_entry = (state_q == GAP_D) && (state_d == DISPENSE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      portions    <= '0;
      cap_reached <= (MAX_PORTIONS == '0);
    end else begin
      if (count_clr)
        portions <= '0;
      else if (dispense_entry && (portions != '1))
        portions <= portions + 1'b1;
      cap_reached <= (portions >= MAX_PORTIONS);
    end
  end

`ifdef DISPENSE_MANUAL_EN
  logic req_rise;

  req_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync_edge (
    .clk  (clk),
    .reset(reset),
    .din  (manual_req),
    .rise (req_rise)
  );

  // Presses during GAP_D/DISPENSE are dropped; repeated presses collapse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pend_q <= 1'b0;
    else if (state_q == GAP_D)
      pend_q <= 1'b0;
    else if (req_rise && (state_q != DISPENSE))
      pend_q <= 1'b1;
  end
`else
  logic unused_manual_req;
  assign unused_manual_req = manual_req | (SYNC_STAGES < 2);
  assign pend_q = 1'b0;
`endif

endmodule

// File: doc/dispense_scheduler.md
# dispense_scheduler

Top-level sequencer for the pet food dispenser. It drives the `Temporizador` timer through `init`/`limite` and watches its `numero` output to alternate between an inter-meal wait interval and a gate-open dispense phase. It arbitrates scheduled meals against a manual pushbutton request, skips dispensing when the bowl is full, and keeps a saturating portion count with a daily cap.

## Interface
- `MAX_PORTIONS`, 8'd6: dispenses allowed before `cap_reached` blocks further gate openings.
- `SYNC_STAGES`, 2: flip-flop depth of the `manual_req` synchronizer (≥2).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: scheduled operation on/off.
- `interval_lim` in 8: wait length in timer counts, latched at wait-phase entry.
- `dispense_lim` in 8: gate-open length in timer counts, latched at dispense-phase entry.
- `manual_req` in 1: raw pushbutton input, asynchronous, active-high.
- `bowl_full` in 1: bowl sensor; when 1, the current dispense is skipped.
- `count_clr` in 1: synchronous clear of `portions`.
- `tmr_numero` in 16: timer count.
- `tmr_init` out 1: timer run; 0 clears the timer.
- `tmr_limite` out 8: limit presented to the timer.
- `gate_open` out 1: servo/gate drive.
- `portions` out 8: dispenses since the last clear, saturating at 255.
- `busy` out 1: state ≠ IDLE.
- `cap_reached` out 1: `portions >= MAX_PORTIONS`.

## Operation
- Phase done is `tmr_numero >= {8'h00, tmr_limite}`, sampled every cycle while `tmr_init=1`.
- States:
  - IDLE: `tmr_init=0`.
    - `pend` (manual pending) → GAP_D.
    - Otherwise `enable` → WAIT, latching `interval_lim`.
  - WAIT: `tmr_init=1`.
    - Done or `pend` → GAP_D (a manual request aborts the wait).
    - `!enable` → IDLE.
    - `pend` has priority over `!enable`.
  - GAP_D: `tmr_init=0` for exactly 1 cycle; latches `dispense_lim`.
    - `bowl_full | cap_reached` → GAP_W (skip: no gate, no count).
    - Otherwise → DISPENSE.
    - `pend` is cleared here in both cases.
  - DISPENSE: `tmr_init=1`, `gate_open=1`.
    - `portions` increments on entry.
    - Done → GAP_W.
    - `enable` is ignored, so a portion always completes.
  - GAP_W: `tmr_init=0` for 1 cycle; latches `interval_lim`.
    - `enable` → WAIT, else → IDLE.
- `pend` is set by a synchronized rising edge of `manual_req`.
  - Edges arriving while in GAP_D or DISPENSE are discarded.
  - Multiple edges before service collapse into one request.
- `count_clr` zeroes `portions` next edge; it wins over a simultaneous increment.
- Limit 0: the phase lasts exactly 1 cycle.

## Timing
- Reset (async, immediate): state IDLE; `tmr_init=0`, `tmr_limite=0`, `gate_open=0`, `portions=0`, `busy=0`, `cap_reached=0` (for `MAX_PORTIONS>0`); `pend=0`; synchronizer cleared.
- Reset mid-DISPENSE closes the gate asynchronously.
- All outputs are registered; no combinational input→output paths.
- Timer model (bench contract): it counts +1 per clock while `init=1` and clears to 0 while `init=0`.
  - WAIT lasts `interval_lim+1` cycles; DISPENSE lasts `dispense_lim+1` cycles.
  - Scheduled period = `interval_lim + dispense_lim + 4` cycles.
- Manual latency: button edge to `pend=1` takes `SYNC_STAGES+1` cycles; then 1 cycle to GAP_D and 1 cycle to `gate_open`.
- `cap_reached` updates the cycle after `portions` changes.

## Configuration
- `DISPENSE_MANUAL_EN` defined: synchronizer, edge detect and `pend` logic are present, as described above.
- Not defined: the `manual_req` port remains but is ignored, `pend` is constant 0, and only scheduled dispenses occur.

## Structure
- Package `dispenser_pkg`:
  - state enum (IDLE, WAIT, GAP_D, DISPENSE, GAP_W)
  - `TMR_LIM_W=8`, `TMR_CNT_W=16`, `PORT_W=8`
- Sub-module `req_sync_edge`: `SYNC_STAGES`-deep synchronizer plus rising-edge pulse, asynchronous active-low reset. It is instantiated only under `DISPENSE_MANUAL_EN`.

## Test plan
- Scheduled cycle: `enable=1`, `interval_lim=5`, `dispense_lim=3`, `bowl_full=0` → WAIT 6 cycles, 1 gap, `gate_open=1` for 4 cycles, 1 gap; period 12 cycles; `portions` increments by 1 per period.
- Bowl full: `bowl_full=1` throughout → `gate_open` never asserts, `portions` stays 0, `tmr_init` still toggles with a 12-cycle period minus the dispense phase.
- Manual abort: `enable=1`, `interval_lim=200`; pulse `manual_req` 3 cycles after WAIT entry → `gate_open` rises `SYNC_STAGES+3` cycles after the edge; a second press during the gate is discarded.
- Cap and clear: `MAX_PORTIONS=2`, short limits → after 2 dispenses `cap_reached=1` and the gate stays closed; `count_clr` pulse → `portions=0`, next period dispenses.
- Reset mid-dispense: assert `reset=0` in the 2nd DISPENSE cycle → `gate_open`, `tmr_init`, `portions` are 0 before the next edge; after release, the FSM restarts from IDLE.
- Limit zero / disable: `interval_lim=0`, `dispense_lim=0` → WAIT and DISPENSE last 1 cycle each; dropping `enable` during DISPENSE completes the portion, then goes GAP_W → IDLE with `busy=0`.
